// File: rtl/chess_clock_multi_if.sv
// Control/display bus of the multi-player chess clock.
// The master side drives reg_a; the clock drives segdata and flag.
interface chess_clock_multi_if #(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic [31:0]            reg_a;
    logic [31:0]            segdata;
    logic [NUM_PLAYERS-1:0] flag;

    modport master (output reg_a, input segdata, input flag);
    modport slave  (input reg_a, output segdata, output flag);
endinterface

// File: rtl/chess_clock_multi.sv
// N-player countdown chess clock with Fischer increment.
// Drives the nibble-coded segdata word for the seven-segment scanner.
module chess_clock_multi #(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned INIT_MIN    = 10,
    parameter int unsigned INC_SEC     = 0
) (
    input logic                segclk,
    input logic                resetn,
    chess_clock_multi_if.slave bus
);

    localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
    localparam int unsigned PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [23:0] INIT_TIME = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10), 16'h0000};
    localparam logic [23:0] MAX_TIME  = 24'h995999;
    localparam logic [5:0]  INC_W     = 6'(INC_SEC);

    // Time layout: {m10, m1, s10, s1, c10, c1}; the s10 digit rolls at 5.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_add_sec(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        if (t[23:8] == 16'h9959) return MAX_TIME;
        r     = t;
        carry = 1'b1;
        for (int i = 2; i < 6; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == ((i == 3) ? 4'd5 : 4'd9)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [23:0]            time_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] flag_q;
    logic [NUM_PLAYERS-1:0] flag_out_q;
    logic [3:0]             active_q;
    logic [3:0]             last_q;
    logic [3:0]             inc_player_q;
    logic [5:0]             inc_pending_q;
    logic [PW-1:0]          presc_q;
    logic                   load_q;
    logic [31:0]            segdata_q;

    logic        active_valid;
    logic        load_rise;
    logic        running;
    logic        tick;
    logic [3:0]  shown;
    logic [23:0] shown_time;
    logic [15:0] player_code;
    logic [15:0] digits;
    logic        unused_reg_a;

    assign unused_reg_a = ^bus.reg_a[31:5];

    assign active_valid = (active_q != 4'd0) && (active_q <= 4'(NUM_PLAYERS));
    assign load_rise    = bus.reg_a[4] & ~load_q;
    assign running      = active_valid && (flag_q == '0) && (inc_pending_q == 6'd0) && !load_rise;
    assign tick         = running && (presc_q == PRESC_MAX);
    assign shown        = active_valid ? active_q : last_q;
    assign player_code  = active_valid ? {4'hF, active_q, 4'hE, 4'hF} : 16'hBCBD;
    // Below one minute the display trades minutes for centiseconds.
    assign digits       = (shown_time[23:16] != 8'h00) ? shown_time[23:8] : shown_time[15:0];

    always_comb begin
        shown_time = time_q[0];
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            if (shown == 4'(p + 1)) shown_time = time_q[p];
        end
    end

    always_ff @(posedge segclk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < int'(NUM_PLAYERS); p++) time_q[p] <= INIT_TIME;
            flag_q        <= '0;
            flag_out_q    <= '0;
            active_q      <= 4'd0;
            last_q        <= 4'd1;
            inc_player_q  <= 4'd0;
            inc_pending_q <= 6'd0;
            presc_q       <= '0;
            load_q        <= 1'b0;
            segdata_q     <= {16'hBCBD, INIT_TIME[23:8]};
        end else begin
            load_q     <= bus.reg_a[4];
            segdata_q  <= {player_code, digits};
            flag_out_q <= flag_q;
            if (active_valid) last_q <= active_q;

            if (load_rise) begin
                for (int p = 0; p < int'(NUM_PLAYERS); p++) time_q[p] <= INIT_TIME;
                flag_q        <= '0;
                inc_pending_q <= 6'd0;
                presc_q       <= '0;
                active_q      <= bus.reg_a[3:0];
            end else begin
                if (running) presc_q <= tick ? '0 : presc_q + 1'b1;
                for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
                    if (tick && active_q == 4'(p + 1)) begin
                        time_q[p] <= bcd_dec(time_q[p]);
                        if (time_q[p] == 24'h000001) flag_q[p] <= 1'b1;
                    end
                    if (inc_pending_q != 6'd0 && inc_player_q == 4'(p + 1)) begin
                        time_q[p] <= bcd_add_sec(time_q[p]);
                    end
                end
                // The reg_a sample is frozen while an increment is being applied.
                if (inc_pending_q != 6'd0) begin
                    inc_pending_q <= inc_pending_q - 6'd1;
                end else begin
                    active_q <= bus.reg_a[3:0];
                    if (active_valid && bus.reg_a[3:0] != active_q && flag_q == '0
                        && INC_SEC != 0) begin
                        inc_pending_q <= INC_W;
                        inc_player_q  <= active_q;
                    end
                end
            end
        end
    end

    assign bus.segdata = segdata_q;
    assign bus.flag    = flag_out_q;

endmodule

// File: tb/tb_chess_clock_multi.sv
// Scoreboard bench for chess_clock_multi: two parameterisations checked
// every cycle against a centisecond-based behavioural model.
module tb_chess_clock_multi;

    logic segclk = 1'b0;
    logic resetn;

    always #5 segclk = ~segclk;

    chess_clock_multi_if #(.NUM_PLAYERS(2)) bus_a ();
    chess_clock_multi_if #(.NUM_PLAYERS(3)) bus_b ();

    chess_clock_multi #(
        .CLK_HZ(200), .TICK_HZ(100), .NUM_PLAYERS(2), .INIT_MIN(10), .INC_SEC(5)
    ) dut_a (
        .segclk(segclk),
        .resetn(resetn),
        .bus   (bus_a)
    );

    chess_clock_multi #(
        .CLK_HZ(100), .TICK_HZ(100), .NUM_PLAYERS(3), .INIT_MIN(1), .INC_SEC(30)
    ) dut_b (
        .segclk(segclk),
        .resetn(resetn),
        .bus   (bus_b)
    );

    typedef struct packed {
        logic [31:0] seg;
        logic [3:0]  flg;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state, index 0 = dut_a, 1 = dut_b; times in centiseconds.
    int tm [2][10];
    int flg [2], act [2], last [2], presc [2], pend [2], incp [2], ldq [2];
    int div_m [2], inc_m [2], init_m [2], np_m [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit valid(input int i, input int a);
        return a >= 1 && a <= np_m[i];
    endfunction

    function automatic logic [31:0] model_out(input int i);
        int s, t, m, sec, cs;
        logic [15:0] code, dig;
        if (valid(i, act[i])) begin
            s    = act[i];
            code = {4'hF, 4'(act[i]), 4'hE, 4'hF};
        end else begin
            s    = last[i];
            code = 16'hBCBD;
        end
        t   = tm[i][s];
        m   = t / 6000;
        sec = (t / 100) % 60;
        cs  = t % 100;
        if (m >= 1) dig = {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
        else        dig = {4'(sec / 10), 4'(sec % 10), 4'(cs / 10), 4'(cs % 10)};
        return {code, dig};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 10; p++) tm[i][p] = init_m[i] * 6000;
            flg[i] = 0; act[i] = 0; last[i] = 1; presc[i] = 0;
            pend[i] = 0; incp[i] = 0; ldq[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic [4:0] ra);
        int a_old, f_old, a_new;
        bit v, load, running, tick;
        a_old   = act[i];
        f_old   = flg[i];
        a_new   = int'(ra[3:0]);
        v       = valid(i, a_old);
        load    = ra[4] && ldq[i] == 0;
        running = v && f_old == 0 && pend[i] == 0 && !load;
        tick    = running && presc[i] == div_m[i] - 1;
        if (load) begin
            for (int p = 0; p < 10; p++) tm[i][p] = init_m[i] * 6000;
            flg[i] = 0; pend[i] = 0; presc[i] = 0; act[i] = a_new;
        end else begin
            if (running) presc[i] = tick ? 0 : presc[i] + 1;
            if (tick) begin
                tm[i][a_old] = tm[i][a_old] - 1;
                if (tm[i][a_old] == 0) flg[i] = flg[i] | (1 << (a_old - 1));
            end
            if (pend[i] > 0) begin
                tm[i][incp[i]] = (tm[i][incp[i]] + 100 > 599999) ? 599999 : tm[i][incp[i]] + 100;
                pend[i] = pend[i] - 1;
            end else begin
                if (v && a_new != a_old && f_old == 0 && inc_m[i] > 0) begin
                    pend[i] = inc_m[i];
                    incp[i] = a_old;
                end
                act[i] = a_new;
            end
        end
        ldq[i] = int'(ra[4]);
        if (v) last[i] = a_old;
    endtask

    // Starts and ends on a falling edge; outputs are compared 1 ns after the rising edge.
    task automatic cycle(input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        bus_a.reg_a = {27'($urandom), ra0};
        bus_b.reg_a = {27'($urandom), ra1};
        exp_q.push_back('{seg: model_out(0), flg: 4'(flg[0])});
        exp_q.push_back('{seg: model_out(1), flg: 4'(flg[1])});
        model_step(0, ra0);
        model_step(1, ra1);
        @(posedge segclk);
        #1;
        e = exp_q.pop_front();
        check("seg_a", bus_a.segdata, e.seg);
        check("flag_a", {30'h0, bus_a.flag}, {28'h0, e.flg});
        e = exp_q.pop_front();
        check("seg_b", bus_b.segdata, e.seg);
        check("flag_b", {29'h0, bus_b.flag}, {28'h0, e.flg});
        @(negedge segclk);
    endtask

    initial begin
        int guard;
        div_m  = '{2, 1};
        inc_m  = '{5, 30};
        init_m = '{10, 1};
        np_m   = '{2, 3};
        model_reset();
        resetn      = 1'b0;
        bus_a.reg_a = 32'h0;
        bus_b.reg_a = 32'h0;
        repeat (2) @(negedge segclk);
        check("rst_seg_a", bus_a.segdata, 32'hBCBD1000);
        check("rst_flag_a", {30'h0, bus_a.flag}, 32'h0);
        check("rst_seg_b", bus_b.segdata, 32'hBCBD0100);
        resetn = 1'b1;

        // Idle after reset: nothing moves.
        repeat (200) cycle(5'h00, 5'h00);
        check("a_idle_hold", bus_a.segdata, 32'hBCBD1000);

        // Player 1 of dut_a counts down, then hands off to player 2.
        repeat (150) cycle(5'h01, 5'h00);
        check("a_run_0959", bus_a.segdata, 32'hF1EF0959);
        repeat (3) cycle(5'h02, 5'h00);
        check("a_swap_code", bus_a.segdata, 32'hF2EF1000);
        repeat (20) cycle(5'h02, 5'h00);
        repeat (10) cycle(5'h07, 5'h00);

        // dut_b player 1 down to 00:58.40, hand-off with increment; reg_a noise ignored.
        guard = 0;
        while (tm[1][1] > 5840 && guard < 1000) begin
            cycle(5'h00, 5'h01);
            guard++;
        end
        cycle(5'h00, 5'h02);
        repeat (3) cycle(5'h00, 5'h03);
        repeat (40) cycle(5'h00, 5'h02);
        repeat (3) cycle(5'h00, 5'h01);
        check("b_inc_p1", bus_b.segdata, 32'hF1EF0128);
        repeat (40) cycle(5'h00, 5'h01);

        // Player 2 runs out of time; game over freezes everything.
        guard = 0;
        while (tm[1][2] > 2 && guard < 20000) begin
            cycle(5'h00, 5'h02);
            guard++;
        end
        repeat (3) cycle(5'h00, 5'h02);
        check("b_timeout_seg", bus_b.segdata, 32'hF2EF0000);
        check("b_timeout_flag", {29'h0, bus_b.flag}, 32'h2);
        repeat (3) cycle(5'h00, 5'h03);
        repeat (3) cycle(5'h00, 5'h01);
        check("b_flag_held", {29'h0, bus_b.flag}, 32'h2);

        // Load: one reload per rising edge, held level acts once.
        repeat (2) cycle(5'h00, 5'h11);
        check("b_load_flag", {29'h0, bus_b.flag}, 32'h0);
        repeat (3) cycle(5'h00, 5'h11);
        repeat (2) cycle(5'h00, 5'h01);
        cycle(5'h00, 5'h11);
        repeat (5) cycle(5'h00, 5'h01);
        repeat (3) cycle(5'h10, 5'h00);

        // Alternate players until both saturate at 99:59.99.
        repeat (450) begin
            repeat (35) cycle(5'h00, 5'h01);
            repeat (35) cycle(5'h00, 5'h02);
        end
        repeat (40) cycle(5'h00, 5'h00);
        check("b_saturate", bus_b.segdata, 32'hBCBD9959);

        // Asynchronous reset in the middle of an increment.
        repeat (5) cycle(5'h01, 5'h01);
        repeat (2) cycle(5'h02, 5'h02);
        #3 resetn = 1'b0;
        #1;
        check("arst_seg_a", bus_a.segdata, 32'hBCBD1000);
        check("arst_seg_b", bus_b.segdata, 32'hBCBD0100);
        check("arst_flag_b", {29'h0, bus_b.flag}, 32'h0);
        @(negedge segclk);
        resetn = 1'b1;
        model_reset();
        repeat (20) cycle(5'h00, 5'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/chess_clock_multi.md
Name: chess_clock_multi

Overview:
- N-player countdown chess clock for the timer seven-segment IP; successor to the fixed two-player up-counting timer.
- Keeps a per-player BCD remaining time of the form MM:SS.cc and adds a Fischer increment on each move hand-off.
- Flags timeouts and produces the same 32-bit nibble-coded segdata word consumed by the seven-segment scanner.
- Display switches between MM:SS and SS.cc below one minute.

Parameters:
- CLK_HZ, 25000000, segclk frequency in Hz.
- TICK_HZ, 100, countdown resolution in Hz (centiseconds); CLK_HZ/TICK_HZ must be an integer.
- NUM_PLAYERS, 2, number of player timers, range 2..9.
- INIT_MIN, 10, initial minutes per player, range 1..99.
- INC_SEC, 0, seconds added to the moving player on hand-off, range 0..59.

Ports:
- segclk, input, 1, system clock (25 MHz).
- resetn, input, 1, asynchronous active-low reset.
- reg_a, input, 32, control register. [3:0] is the active player (0 = paused, 1..NUM_PLAYERS = running, any other value = paused). [4] is load; its rising edge re-initialises the game. Other bits are ignored.
- segdata, output, 32, display word: {player_code[15:0], d3, d2, d1, d0}, each d a 4-bit BCD digit.
- flag, output, NUM_PLAYERS, one-hot timeout flag; bit p-1 belongs to player p.

Behaviour:
- Reset (async, resetn low):
  - Every player's time = INIT_MIN:00.00.
  - flag = 0, active = 0, shown player = 1, prescaler = 0, inc_pending = 0, load edge detector = 0.
  - segdata = {16'hBCBD, INIT_MIN display}; with defaults segdata = 32'hBCBD1000.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 (0..249999 by default) only while running.
  - Emits a one-cycle tick on wrap.
  - Holds its value while paused (no reset on pause).
- Running means: active in 1..NUM_PLAYERS, flag == 0, inc_pending == 0, and no load this cycle.
- Countdown:
  - Each tick decrements the active player's BCD time by 0.01 s, with borrow chain c1 → c10 → s1 → s10 (s10 wraps 0 → 5) → m1 → m10.
  - Tick on 00:00.01 gives 00:00.00; flag[active-1] is set in the same cycle.
  - Once any flag is set, all counting stops (game over) until load.
- Hand-off:
  - reg_a[3:0] is sampled every cycle only when inc_pending == 0; a change is registered into active one cycle later.
  - When active changes from a valid p to any other value, inc_pending = INC_SEC for player p, unless flag is set or INC_SEC = 0.
  - While inc_pending > 0: add 1 s to player p per cycle (s1 → s10 carry at 59 → m1 → m10), decrement inc_pending, and freeze the prescaler and the reg_a sample.
  - Addition saturates at 99:59.99.
  - The increment completes in INC_SEC cycles.
- Load:
  - A rising edge of reg_a[4] gives, next cycle: all times = INIT, flag = 0, inc_pending = 0, prescaler = 0.
  - active takes the reg_a[3:0] value sampled that cycle.
  - Load has priority over tick, increment and hand-off in the same cycle.
  - A held-high load acts once.
- Shown player:
  - Equals active when active is valid.
  - Otherwise the last valid active player (initially 1).
- player_code:
  - Active valid: {4'hF, p[3:0], 4'hE, 4'hF} ("_pP_").
  - Otherwise: 16'hBCBD ("nonE").
- Time digits (shown player):
  - If minutes ≥ 1: {m10, m1, s10, s1}.
  - Else: {s10, s1, c10, c1}.
- segdata and flag are registered; one cycle of latency after the state change.

Test Plan:
- Reset with defaults → segdata = 32'hBCBD1000 and flag = 2'b00; the value holds for 1e6 cycles.
- Set reg_a = 1 with CLK_HZ overridden to 100 (tick every cycle) → after 100 ticks the time shows 09:59 and segdata = 32'hF1EF0959. Setting reg_a = 2 then switches the code to 32'hF2EF1000.
- INC_SEC = 5, player 1 at 00:58.40 hands off to 2 → within 5 cycles player 1 = 01:03.40. Re-show player 1: segdata low half = 16'h0103. reg_a changes during those cycles are ignored until done.
- Player 2 at 00:00.02 running → two ticks later flag = 2'b10 and segdata low = 16'h0000. Further ticks and hand-offs cause no change.
- Raise reg_a[4] while flagged → next cycle flag = 0 and times = 10:00.00. Holding bit 4 high does not reload again; a second rising edge reloads.
- Assert resetn low mid-increment → immediately segdata = 32'hBCBD1000 and inc_pending is cleared. Player at 99:59.50 with INC_SEC = 30 → saturates at 99:59.99.
